// File: rtl/lighting_pkg.sv
// ----------------------------------------------------------------------------
// lighting_pkg: shared state encodings and widths for the lighting block. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package lighting_pkg;

  localparam int BRIGHT_W = 8;

  typedef enum logic [1:0] {
    ST_OFF  = 2'b00,
    ST_ON   = 2'b01,
    ST_HOLD = 2'b10,
    ST_FADE = 2'b11
  } state_t;

endpackage

`default_nettype wire

// File: rtl/lighting_state_reg.sv
// ----------------------------------------------------------------------------
// lighting_state_reg: 2-bit lighting state register, async clear to OFF. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module lighting_state_reg
  import lighting_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  state_t next_state,
  output state_t state
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_OFF;
    end else begin
      state <= next_state;
    end
  end

endmodule

`default_nettype wire

// File: rtl/lighting_sequencer.sv
// ----------------------------------------------------------------------------
// lighting_sequencer: occupancy/ambient driven lamp sequencer with hold, fade and PWM. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module lighting_sequencer
  import lighting_pkg::*;
#(
  parameter int HOLD_CYCLES      = 1000,
  parameter int FADE_STEP_CYCLES = 4,
  parameter int MAX_LEVEL        = 255
) (
  input  logic                Clock,
  input  logic                Reset_n,
  input  logic                Motion,
  input  logic                Dark,
  input  logic                Force_Off,
  output logic [1:0]          Present_State,
  output logic [BRIGHT_W-1:0] Brightness,
  output logic                Light_PWM,
  output logic                Light_On,
  output logic                Hold_Expired
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int STEP_W = (FADE_STEP_CYCLES > 1) ? $clog2(FADE_STEP_CYCLES) : 1;
  localparam logic [HOLD_W-1:0]   HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [STEP_W-1:0]   STEP_LOAD = STEP_W'(FADE_STEP_CYCLES - 1);
  localparam logic [BRIGHT_W-1:0] FULL      = BRIGHT_W'(MAX_LEVEL);

  logic                motion_meta, motion_s;
  logic                dark_meta, dark_s;
  state_t              state, next_state;
  logic [HOLD_W-1:0]   hold_cnt, hold_cnt_nxt;
  logic [STEP_W-1:0]   step_cnt, step_cnt_nxt;
  logic [BRIGHT_W-1:0] bright_nxt;
  logic                expired_nxt;
  logic [7:0]          pwm_cnt;

  lighting_state_reg u_state_reg (
    .clk        (Clock),
    .rst_n      (Reset_n),
    .next_state (next_state),
    .state      (state)
  );

  always_comb begin
    next_state   = state;
    hold_cnt_nxt = hold_cnt;
    step_cnt_nxt = step_cnt;
    bright_nxt   = Brightness;
    expired_nxt  = 1'b0;
    if (Force_Off) begin
      next_state = ST_OFF;
      bright_nxt = '0;
    end else begin
      case (state)
        ST_OFF: begin
          bright_nxt = '0;
          if (motion_s && dark_s) begin
            next_state = ST_ON;
            bright_nxt = FULL;
          end
        end
        ST_ON: begin
          bright_nxt = FULL;
          if (!motion_s) begin
            next_state   = ST_HOLD;
            hold_cnt_nxt = HOLD_LOAD;
          end
        end
        ST_HOLD: begin
          bright_nxt = FULL;
          if (motion_s) begin
            next_state = ST_ON;
          end else if (hold_cnt == '0) begin
            next_state   = ST_FADE;
            expired_nxt  = 1'b1;
            step_cnt_nxt = STEP_LOAD;
          end else begin
            hold_cnt_nxt = hold_cnt - 1'b1;
          end
        end
        ST_FADE: begin
          if (motion_s && dark_s) begin
            next_state = ST_ON;
            bright_nxt = FULL;
          end else if (step_cnt == '0) begin
            step_cnt_nxt = STEP_LOAD;
            // Last step lands on zero and leaves the fade in the same cycle.
            if (Brightness <= 8'd1) begin
              bright_nxt = '0;
              next_state = ST_OFF;
            end else begin
              bright_nxt = Brightness - 1'b1;
            end
          end else begin
            step_cnt_nxt = step_cnt - 1'b1;
          end
        end
        default: begin
          next_state = ST_OFF;
          bright_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      motion_meta  <= 1'b0;
      motion_s     <= 1'b0;
      dark_meta    <= 1'b0;
      dark_s       <= 1'b0;
      hold_cnt     <= '0;
      step_cnt     <= '0;
      Brightness   <= '0;
      Hold_Expired <= 1'b0;
      pwm_cnt      <= '0;
      Light_PWM    <= 1'b0;
    end else begin
      motion_meta  <= Motion;
      motion_s     <= motion_meta;
      dark_meta    <= Dark;
      dark_s       <= dark_meta;
      hold_cnt     <= hold_cnt_nxt;
      step_cnt     <= step_cnt_nxt;
      Brightness   <= bright_nxt;
      Hold_Expired <= expired_nxt;
      pwm_cnt      <= pwm_cnt + 8'd1;
      Light_PWM    <= (pwm_cnt < Brightness);
    end
  end

  assign Present_State = state;
  assign Light_On      = (state != ST_OFF);

endmodule

`default_nettype wire

// File: tb/tb_lighting_sequencer.sv
// ----------------------------------------------------------------------------
// tb_lighting_sequencer: directed and random stimulus against a cycle model. Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_lighting_sequencer;

  localparam int HOLD = 8;
  localparam int STEP = 2;
  localparam int MAXL = 4;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       motion = 1'b0, dark = 1'b0, force_off = 1'b0;
  logic [1:0] present_state;
  logic [7:0] brightness;
  logic       light_pwm, light_on, hold_expired;

  int checks = 0;
  int failures = 0;

  lighting_sequencer #(
    .HOLD_CYCLES      (HOLD),
    .FADE_STEP_CYCLES (STEP),
    .MAX_LEVEL        (MAXL)
  ) dut (
    .Clock         (clk),
    .Reset_n       (rst_n),
    .Motion        (motion),
    .Dark          (dark),
    .Force_Off     (force_off),
    .Present_State (present_state),
    .Brightness    (brightness),
    .Light_PWM     (light_pwm),
    .Light_On      (light_on),
    .Hold_Expired  (hold_expired)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0=OFF 1=ON 2=HOLD 3=FADE, timers count elapsed clocks.
  int m_mode = 0, m_hold_el = 0, m_fade_el = 0, m_bright = 0, m_cyc = 0;
  bit m_pwm = 0, m_exp = 0;
  bit m_m1 = 0, m_m2 = 0, m_d1 = 0, m_d2 = 0;
  bit ms, ds;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_hold_el = 0; m_fade_el = 0; m_bright = 0; m_cyc = 0;
      m_pwm = 0; m_exp = 0; m_m1 = 0; m_m2 = 0; m_d1 = 0; m_d2 = 0;
    end else begin
      ms = m_m2;
      ds = m_d2;
      m_pwm = ((m_cyc % 256) < m_bright);
      m_cyc++;
      m_exp = 0;
      if (force_off) begin
        m_mode = 0;
      end else begin
        case (m_mode)
          0: if (ms && ds) m_mode = 1;
          1: if (!ms) begin m_mode = 2; m_hold_el = 0; end
          2: begin
            if (ms) m_mode = 1;
            else if (m_hold_el == HOLD - 1) begin m_mode = 3; m_fade_el = 0; m_exp = 1; end
            else m_hold_el++;
          end
          default: begin
            if (ms && ds) m_mode = 1;
            else begin
              m_fade_el++;
              if (m_fade_el == MAXL * STEP) m_mode = 0;
            end
          end
        endcase
      end
      m_bright = (m_mode == 0) ? 0 : (m_mode == 3) ? (MAXL - m_fade_el / STEP) : MAXL;
      m_m2 = m_m1; m_m1 = motion;
      m_d2 = m_d1; m_d1 = dark;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("m_state", present_state, m_mode);
      check("m_bright", brightness, m_bright);
      check("m_pwm", light_pwm, m_pwm);
      check("m_light_on", light_on, (m_mode != 0));
      check("m_expired", hold_expired, m_exp);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input logic [1:0] st, input int bound, input string name);
    int n = 0;
    while (present_state !== st && n < bound) begin
      @(negedge clk);
      n++;
    end
    check(name, present_state, st);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_state"}, present_state, 0);
    check({name, "_bright"}, brightness, 0);
    check({name, "_pwm"}, light_pwm, 0);
    check({name, "_light_on"}, light_on, 0);
    check({name, "_expired"}, hold_expired, 0);
  endtask

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int n, cnt;
    bit saw_on;
    tick(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    tick(1);

    // Motion+Dark: ON three clocks after the pin edge.
    dark = 1'b1; motion = 1'b1;
    tick(2);
    check("t1_still_off", present_state, 0);
    tick(1);
    check("t1_on", present_state, 1);
    check("t1_bright", brightness, 4);
    check("t1_light_on", light_on, 1);

    // Motion drop: 8 clocks of HOLD, then the fade staircase.
    tick(3);
    motion = 1'b0;
    tick(3);
    check("t2_hold_entry", present_state, 2);
    n = 0;
    while (present_state == 2'd2 && n < 20) begin tick(1); n++; end
    check("t2_hold_len", n, 8);
    check("t2_fade", present_state, 3);
    check("t2_expired", hold_expired, 1);
    for (int i = 0; i < 8; i++) begin
      check("t2_fade_state", present_state, 3);
      check("t2_fade_bright", brightness, 4 - i / 2);
      if (i == 1) check("t2_expired_low", hold_expired, 0);
      tick(1);
    end
    check("t2_off", present_state, 0);
    check("t2_off_bright", brightness, 0);

    // Motion returns on HOLD clock 5, later drop restarts a full hold.
    motion = 1'b1;
    tick(3);
    check("t3_on", present_state, 1);
    motion = 1'b0;
    tick(3);
    check("t3_hold", present_state, 2);
    tick(2);
    motion = 1'b1;
    tick(2);
    check("t3_hold5", present_state, 2);
    tick(1);
    check("t3_back_on", present_state, 1);
    check("t3_back_bright", brightness, 4);
    motion = 1'b0;
    tick(3);
    n = 0;
    while (present_state == 2'd2 && n < 20) begin tick(1); n++; end
    check("t3_hold_len", n, 8);

    // Motion during fade at level 2: with Dark, snap back to ON.
    tick(4);
    check("t4_bright2", brightness, 2);
    motion = 1'b1;
    wait_state(2'd1, 4, "t4_on");
    check("t4_on_bright", brightness, 4);
    motion = 1'b0;
    tick(3);
    check("t4_hold", present_state, 2);
    tick(8);
    check("t4_fade", present_state, 3);
    tick(4);
    check("t4_bright2b", brightness, 2);
    dark = 1'b0; motion = 1'b1;
    n = 0; saw_on = 1'b0;
    while (present_state != 2'd0 && n < 12) begin
      if (present_state == 2'd1) saw_on = 1'b1;
      tick(1); n++;
    end
    check("t4_no_on", saw_on, 0);
    check("t4_off", present_state, 0);
    tick(3);
    check("t4_stay_off", present_state, 0);

    // Force_Off in ON, HOLD and FADE.
    dark = 1'b1;
    wait_state(2'd1, 5, "t5_on");
    force_off = 1'b1;
    tick(1);
    check("t5_on_forced", present_state, 0);
    check("t5_on_forced_bright", brightness, 0);
    force_off = 1'b0;
    tick(1);
    check("t5_reenter", present_state, 1);
    check("t5_reenter_bright", brightness, 4);
    motion = 1'b0;
    wait_state(2'd2, 5, "t5_hold");
    tick(2);
    force_off = 1'b1;
    tick(1);
    check("t5_hold_forced", present_state, 0);
    check("t5_hold_forced_bright", brightness, 0);
    force_off = 1'b0;
    motion = 1'b1;
    wait_state(2'd1, 5, "t5_on2");
    motion = 1'b0;
    wait_state(2'd3, 20, "t5_fade");
    tick(3);
    force_off = 1'b1;
    tick(1);
    check("t5_fade_forced", present_state, 0);
    check("t5_fade_forced_bright", brightness, 0);
    force_off = 1'b0;

    // Async reset mid-fade between edges, then PWM duty at level 4.
    motion = 1'b1;
    wait_state(2'd1, 5, "t6_on");
    motion = 1'b0;
    wait_state(2'd3, 20, "t6_fade");
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("t6_async");
    tick(1);
    rst_n = 1'b1;
    motion = 1'b1;
    wait_state(2'd1, 6, "t6_on2");
    tick(2);
    cnt = 0;
    for (int i = 0; i < 256; i++) begin
      tick(1);
      cnt += int'(light_pwm);
    end
    check("t6_pwm_duty", cnt, 4);

    // Random traffic, cross-checked every cycle by the model.
    for (int i = 0; i < 3000; i++) begin
      tick(1);
      if ($urandom_range(0, 15) == 0) motion = ~motion;
      if ($urandom_range(0, 31) == 0) dark = ~dark;
      force_off = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 499) == 0) begin
        #2 rst_n = 1'b0;
        #1 check_all_zero("rnd_async");
        tick(1);
        rst_n = 1'b1;
      end
    end
    force_off = 1'b0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
